// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller for the execute stage.
//
// Decodes SYSTEM instructions (CSR ops, ecall, ebreak, mret), arbitrates traps between
// external interrupts, external exceptions and illegal CSR accesses, and redirects fetch.
// Outputs are combinational from the current instruction and CSR state; state commits on
// the rising edge when the stage is valid and not halted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hlt_i           stall; freezes everything except mcycle and the mip sample
//   valid_i         instruction present and not flushed
//   system_i        SYSTEM opcode
//   funct3_i        CSR op / PRIV selector
//   csr_addr_i      CSR address (immediate[11:0])
//   rs1_idx_i       rs1 index, doubles as zimm
//   rd_idx_i        destination register index
//   r1_i, pc_i      rs1 value, instruction pc
//   exception_i     external synchronous exception, with exc_cause_i / exc_tval_i
//   retire_i        instruction completes this cycle
//   irq_i           level-sensitive external interrupt lines
//   result_o        old CSR value for rd
//   write_o         rd write enable
//   override_o      redirect fetch to newpc_o
//   newpc_o         redirect target
//   trap_o          trap taken this cycle
module csr_trap_unit #(
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [31:0] MTVEC_RESET   = 32'h0005_0004,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter logic [31:0] MISA_VALUE    = 32'h0000_0000,
  parameter logic [31:0] HART_ID       = 32'h0000_0000,
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hlt_i,
  input  logic               valid_i,
  input  logic               system_i,
  input  logic [2:0]         funct3_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [4:0]         rs1_idx_i,
  input  logic [4:0]         rd_idx_i,
  input  logic [31:0]        r1_i,
  input  logic [31:0]        pc_i,
  input  logic               exception_i,
  input  logic [4:0]         exc_cause_i,
  input  logic [31:0]        exc_tval_i,
  input  logic               retire_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        result_o,
  output logic               write_o,
  output logic               override_o,
  output logic [31:0]        newpc_o,
  output logic               trap_o
);

  localparam int unsigned CW = COUNTER_WIDTH;
  // MODE bit1 is never stored; bit0 only when vectored mode is supported.
  localparam logic [31:0] MtvecMask = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
  localparam logic [31:0] MtvecRst  = MTVEC_RESET & MtvecMask;

  // State
  logic               status_mie_q, status_mpie_q;
  logic [NUM_IRQ-1:0] mie_q, mip_q;
  logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [CW-1:0]      mcycle_q, mcycle_d, minstret_q, minstret_d;

  // Decode
  logic        is_priv, is_ecall, is_ebreak, is_mret, is_csr, wr_intent, read_only;
  logic [31:0] csr_src;

  assign is_priv   = system_i && (funct3_i == 3'b000);
  assign is_ecall  = is_priv && (csr_addr_i == 12'h000);
  assign is_ebreak = is_priv && (csr_addr_i == 12'h001);
  assign is_mret   = is_priv && (csr_addr_i == 12'h302);
  assign is_csr    = system_i && (funct3_i[1:0] != 2'b00);
  assign csr_src   = funct3_i[2] ? {27'b0, rs1_idx_i} : r1_i;
  // Set/clear with rs1/zimm == 0 is a pure read.
  assign wr_intent = is_csr && ((funct3_i[1:0] == 2'b01) || (rs1_idx_i != 5'd0));
  assign read_only = (csr_addr_i[11:10] == 2'b11) || (csr_addr_i == 12'h301) ||
                     (csr_addr_i == 12'h344);

  // CSR read view
  logic [63:0] mcycle_ext, minstret_ext;
  logic [31:0] mstatus_rd, mie_rd, mip_rd, csr_rdata;
  logic        csr_impl;

  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);
  assign mstatus_rd   = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};
  assign mie_rd       = 32'(mie_q) << 16;
  assign mip_rd       = 32'(mip_q) << 16;

  always_comb begin
    csr_rdata = '0;
    csr_impl  = 1'b1;
    case (csr_addr_i)
      12'h300:          csr_rdata = mstatus_rd;
      12'h301:          csr_rdata = MISA_VALUE;
      12'h304:          csr_rdata = mie_rd;
      12'h305:          csr_rdata = mtvec_q;
      12'h340:          csr_rdata = mscratch_q;
      12'h341:          csr_rdata = mepc_q;
      12'h342:          csr_rdata = mcause_q;
      12'h343:          csr_rdata = mtval_q;
      12'h344:          csr_rdata = mip_rd;
      12'hB00, 12'hC00: csr_rdata = mcycle_ext[31:0];
      12'hB80, 12'hC80: csr_rdata = mcycle_ext[63:32];
      12'hB02, 12'hC02: csr_rdata = minstret_ext[31:0];
      12'hB82, 12'hC82: csr_rdata = minstret_ext[63:32];
      12'hF14:          csr_rdata = HART_ID;
      default:          csr_impl  = 1'b0;
    endcase
  end

  logic csr_illegal;
  assign csr_illegal = is_csr && (!csr_impl || (wr_intent && read_only));

  // CSR write data
  logic [31:0] wdata;
  always_comb begin
    case (funct3_i[1:0])
      2'b10:   wdata = csr_rdata | csr_src;
      2'b11:   wdata = csr_rdata & ~csr_src;
      default: wdata = csr_src;
    endcase
  end

  // Interrupt selection: lowest index wins.
  logic [NUM_IRQ-1:0] irq_active;
  logic [4:0]         irq_code;
  assign irq_active = mip_q & mie_q;

  always_comb begin
    irq_code = 5'd16;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_active[i]) irq_code = 5'(16 + i);
    end
  end

  // Trap arbitration
  logic        trap, is_irq;
  logic [4:0]  cause;
  logic [31:0] tval;

  always_comb begin
    trap   = 1'b0;
    is_irq = 1'b0;
    cause  = 5'd0;
    tval   = 32'd0;
    if (valid_i) begin
      if (status_mie_q && (|irq_active)) begin
        trap   = 1'b1;
        is_irq = 1'b1;
        cause  = irq_code;
      end else if (exception_i) begin
        trap  = 1'b1;
        cause = exc_cause_i;
        tval  = exc_tval_i;
      end else if (csr_illegal) begin
        trap  = 1'b1;
        cause = 5'd2;
      end else if (is_ecall) begin
        trap  = 1'b1;
        cause = 5'd11;
      end else if (is_ebreak) begin
        trap  = 1'b1;
        cause = 5'd3;
        tval  = pc_i;
      end
    end
  end

  logic [31:0] trap_pc;
  logic        do_mret, csr_we, commit;

  assign trap_pc = {mtvec_q[31:2], 2'b00} +
                   ((mtvec_q[0] && is_irq) ? {25'b0, cause, 2'b00} : 32'd0);
  assign do_mret = valid_i && is_mret && !trap;
  assign csr_we  = valid_i && wr_intent && !trap;
  assign commit  = !hlt_i;

  // Outputs
  assign trap_o     = trap;
  assign override_o = trap || do_mret;
  assign newpc_o    = trap ? trap_pc : (do_mret ? mepc_q : 32'd0);
  assign write_o    = valid_i && is_csr && !trap && (rd_idx_i != 5'd0);
  assign result_o   = (valid_i && is_csr && !trap) ? csr_rdata : 32'd0;

  // Counters: a CSR write to either half replaces that half and skips the increment.
  logic inst_inc;
  assign inst_inc = retire_i && !hlt_i && !trap;

  always_comb begin
    mcycle_d   = mcycle_q + CW'(1);
    minstret_d = minstret_q + CW'(inst_inc);
    if (csr_we && commit) begin
      case (csr_addr_i)
        12'hB00: mcycle_d   = CW'({mcycle_ext[63:32], wdata});
        12'hB80: mcycle_d   = CW'({wdata, mcycle_ext[31:0]});
        12'hB02: minstret_d = CW'({minstret_ext[63:32], wdata});
        12'hB82: minstret_d = CW'({wdata, minstret_ext[31:0]});
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= '0;
      mip_q         <= '0;
      mtvec_q       <= MtvecRst;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      mip_q      <= irq_i;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (commit) begin
        if (trap) begin
          mepc_q        <= pc_i & ~32'h3;
          mcause_q      <= {is_irq, 26'b0, cause};
          mtval_q       <= tval;
          status_mpie_q <= status_mie_q;
          status_mie_q  <= 1'b0;
        end else if (do_mret) begin
          status_mie_q  <= status_mpie_q;
          status_mpie_q <= 1'b1;
        end else if (csr_we) begin
          case (csr_addr_i)
            12'h300: begin
              status_mie_q  <= wdata[3];
              status_mpie_q <= wdata[7];
            end
            12'h304: mie_q      <= wdata[16 +: NUM_IRQ];
            12'h305: mtvec_q    <= wdata & MtvecMask;
            12'h340: mscratch_q <= wdata;
            12'h341: mepc_q     <= wdata & ~32'h3;
            12'h342: mcause_q   <= wdata;
            12'h343: mtval_q    <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit (default parameters).
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hlt = 1'b0, valid = 1'b0, system = 1'b0, exception = 1'b0, retire = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_addr = '0;
  logic [4:0]  rs1_idx = '0, rd_idx = '0, exc_cause = '0;
  logic [31:0] r1 = '0, pc = '0, exc_tval = '0;
  logic [3:0]  irq = '0;
  logic [31:0] result, newpc;
  logic        write_en, override, trap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_trap_unit dut (
    .clk         (clk),
    .rst         (rst),
    .hlt_i       (hlt),
    .valid_i     (valid),
    .system_i    (system),
    .funct3_i    (funct3),
    .csr_addr_i  (csr_addr),
    .rs1_idx_i   (rs1_idx),
    .rd_idx_i    (rd_idx),
    .r1_i        (r1),
    .pc_i        (pc),
    .exception_i (exception),
    .exc_cause_i (exc_cause),
    .exc_tval_i  (exc_tval),
    .retire_i    (retire),
    .irq_i       (irq),
    .result_o    (result),
    .write_o     (write_en),
    .override_o  (override),
    .newpc_o     (newpc),
    .trap_o      (trap)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_mie_bit = 0, m_mpie = 0;
  logic [31:0] m_mie = 0, m_mtvec = 32'h0005_0004, m_mscratch = 0, m_mepc = 0;
  logic [31:0] m_mcause = 0, m_mtval = 0;
  logic [63:0] m_cyc = 0, m_ins = 0;
  logic [3:0]  m_mip = 0;

  logic        e_trap, e_irq, e_mret, e_we, e_csr_ok, e_write, e_ovr;
  logic [31:0] e_newpc, e_result, e_cause, e_tval, e_wval;

  function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
    bit ok = 1'b1;
    v = 32'd0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_bit) << 3);
      12'h301: v = 32'd0;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = 32'(m_mip) << 16;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF14: v = 32'd0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  task automatic model_eval();
    logic [31:0] old, src, pend;
    bit impl, ro, intent, is_csr;
    int code;
    e_trap = 0; e_irq = 0; e_mret = 0; e_we = 0; e_csr_ok = 0; e_write = 0; e_ovr = 0;
    e_newpc = 0; e_result = 0; e_cause = 0; e_tval = 0; e_wval = 0;
    code = 0;
    is_csr = system && (funct3 != 3'd0) && (funct3 != 3'd4);
    impl   = m_read(csr_addr, old);
    src    = funct3[2] ? {27'b0, rs1_idx} : r1;
    intent = is_csr && (funct3[1:0] == 2'b01 || rs1_idx != 0);
    ro     = (csr_addr >= 12'hC00) || csr_addr == 12'h301 || csr_addr == 12'h344;
    pend   = m_mie_bit ? ((32'(m_mip) << 16) & m_mie) : 32'd0;
    if (valid) begin
      if (pend != 0) begin
        code = 16;
        while (pend[code] == 1'b0) code++;
        e_trap = 1; e_irq = 1; e_cause = 32'h8000_0000 + 32'(code);
      end else if (exception) begin
        e_trap = 1; e_cause = 32'(exc_cause); e_tval = exc_tval;
      end else if (is_csr && (!impl || (intent && ro))) begin
        e_trap = 1; e_cause = 2;
      end else if (system && funct3 == 0 && csr_addr == 12'h000) begin
        e_trap = 1; e_cause = 11;
      end else if (system && funct3 == 0 && csr_addr == 12'h001) begin
        e_trap = 1; e_cause = 3; e_tval = pc;
      end else if (system && funct3 == 0 && csr_addr == 12'h302) begin
        e_mret = 1;
      end else if (is_csr) begin
        e_csr_ok = 1; e_result = old; e_write = (rd_idx != 0); e_we = intent;
        case (funct3[1:0])
          2'b01:   e_wval = src;
          2'b10:   e_wval = old | src;
          default: e_wval = old & ~src;
        endcase
      end
    end
    if (e_trap) begin
      e_ovr = 1;
      e_newpc = (m_mtvec & ~32'h3) + ((m_mtvec[0] && e_irq) ? 32'(4 * code) : 32'd0);
    end else if (e_mret) begin
      e_ovr = 1; e_newpc = m_mepc;
    end
  endtask

  task automatic model_step();
    logic [63:0] cyc_n, ins_n;
    if (rst) begin
      m_mie_bit = 0; m_mpie = 0; m_mie = 0; m_mtvec = 32'h0005_0004; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0; m_mip = 0;
    end else begin
      cyc_n = m_cyc + 1;
      ins_n = m_ins + ((retire && !hlt && !e_trap) ? 64'd1 : 64'd0);
      if (valid && !hlt) begin
        if (e_trap) begin
          m_mepc = pc & ~32'h3; m_mcause = e_cause; m_mtval = e_tval;
          m_mpie = m_mie_bit; m_mie_bit = 0;
        end else if (e_mret) begin
          m_mie_bit = m_mpie; m_mpie = 1;
        end else if (e_we) begin
          case (csr_addr)
            12'h300: begin m_mie_bit = e_wval[3]; m_mpie = e_wval[7]; end
            12'h304: m_mie = e_wval & 32'h000F_0000;
            12'h305: m_mtvec = e_wval & ~32'h2;
            12'h340: m_mscratch = e_wval;
            12'h341: m_mepc = e_wval & ~32'h3;
            12'h342: m_mcause = e_wval;
            12'h343: m_mtval = e_wval;
            12'hB00: cyc_n = {m_cyc[63:32], e_wval};
            12'hB80: cyc_n = {e_wval, m_cyc[31:0]};
            12'hB02: ins_n = {m_ins[63:32], e_wval};
            12'hB82: ins_n = {e_wval, m_ins[31:0]};
            default: ;
          endcase
        end
      end
      m_cyc = cyc_n; m_ins = ins_n; m_mip = irq;
    end
  endtask

  // Compare process: outputs checked against the model every cycle out of reset.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_eval();
      if (!rst) begin
        chk("trap", 32'(trap), 32'(e_trap));
        chk("override", 32'(override), 32'(e_ovr));
        chk("write", 32'(write_en), 32'(e_write));
        if (e_ovr || !valid) chk("newpc", newpc, e_newpc);
        if (e_csr_ok || !valid) chk("result", result, e_result);
      end
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs,
                    input logic [4:0] rd, input logic [31:0] v, input logic [31:0] p);
    valid = 1; system = 1; funct3 = f3; csr_addr = a; rs1_idx = rs; rd_idx = rd;
    r1 = v; pc = p; exception = 0; retire = 0;
    look();
  endtask

  task automatic exc_op(input logic [4:0] c, input logic [31:0] tv, input logic [31:0] p);
    valid = 1; system = 0; funct3 = 3'd0; csr_addr = 12'h000; rs1_idx = 0; rd_idx = 0;
    pc = p; exception = 1; exc_cause = c; exc_tval = tv; retire = 0;
    look();
  endtask

  task automatic idle();
    valid = 0; system = 0; exception = 0; retire = 0; hlt = 0;
    tick();
  endtask

  task automatic rd_csr(input logic [11:0] a, input string name, input logic [31:0] exp);
    op(3'd2, a, 5'd0, 5'd1, 32'd0, 32'h100);
    chk(name, result, exp);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;

    rd_csr(12'h300, "mstatus_rst", 32'h0000_1800);
    rd_csr(12'h305, "mtvec_rst", 32'h0005_0004);
    rd_csr(12'h342, "mcause_rst", 32'h0);

    op(3'd1, 12'h340, 5'd0, 5'd5, 32'hDEAD_BEEF, 32'h100);
    chk("csrrw_write", 32'(write_en), 32'd1);
    chk("csrrw_old", result, 32'd0);
    tick();
    op(3'd2, 12'h340, 5'd0, 5'd6, 32'h1234_5678, 32'h104);
    chk("csrrs_x0_write", 32'(write_en), 32'd1);
    chk("csrrs_x0_old", result, 32'hDEAD_BEEF);
    tick();
    rd_csr(12'h340, "mscratch_kept", 32'hDEAD_BEEF);
    op(3'd7, 12'h340, 5'd15, 5'd1, 32'd0, 32'h108);
    tick();
    rd_csr(12'h340, "mscratch_rci", 32'hDEAD_BEE0);

    // ecall / mret round trip
    op(3'd6, 12'h300, 5'd8, 5'd0, 32'd0, 32'h10C);
    tick();
    op(3'd0, 12'h000, 5'd0, 5'd0, 32'd0, 32'h200);
    chk("ecall_trap", 32'(trap), 32'd1);
    chk("ecall_newpc", newpc, 32'h0005_0004);
    tick();
    rd_csr(12'h342, "ecall_mcause", 32'd11);
    rd_csr(12'h343, "ecall_mtval", 32'd0);
    rd_csr(12'h341, "ecall_mepc", 32'h200);
    rd_csr(12'h300, "ecall_mstatus", 32'h0000_1880);
    op(3'd0, 12'h302, 5'd0, 5'd0, 32'd0, 32'h300);
    chk("mret_override", 32'(override), 32'd1);
    chk("mret_newpc", newpc, 32'h200);
    tick();
    rd_csr(12'h300, "mret_mstatus", 32'h0000_1888);

    // illegal CSR accesses
    op(3'd1, 12'hF14, 5'd0, 5'd3, 32'd5, 32'h204);
    chk("ro_write_trap", 32'(trap), 32'd1);
    chk("ro_write_wr", 32'(write_en), 32'd0);
    tick();
    rd_csr(12'h342, "illegal_mcause", 32'd2);
    op(3'd2, 12'h7C0, 5'd0, 5'd4, 32'd0, 32'h208);
    chk("unimpl_trap", 32'(trap), 32'd1);
    tick();
    op(3'd2, 12'hF14, 5'd0, 5'd4, 32'd0, 32'h20C);
    tick();
    op(3'd0, 12'h001, 5'd0, 5'd0, 32'd0, 32'h304);
    tick();
    rd_csr(12'h343, "ebreak_mtval", 32'h304);
    op(3'd1, 12'h341, 5'd0, 5'd0, 32'h123, 32'h308);
    tick();
    rd_csr(12'h341, "mepc_mask", 32'h120);

    // vectored interrupt
    op(3'd6, 12'h300, 5'd8, 5'd0, 32'd0, 32'h30C);
    tick();
    op(3'd1, 12'h305, 5'd0, 5'd0, 32'h1003, 32'h310);
    tick();
    rd_csr(12'h305, "mtvec_wr", 32'h1001);
    op(3'd1, 12'h304, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h314);
    tick();
    rd_csr(12'h304, "mie_mask", 32'h000F_0000);
    irq = 4'b0101;
    idle();
    op(3'd1, 12'h340, 5'd0, 5'd5, 32'h1234, 32'h400);
    chk("irq_trap", 32'(trap), 32'd1);
    chk("irq_newpc", newpc, 32'h1040);
    chk("irq_nowrite", 32'(write_en), 32'd0);
    tick();
    rd_csr(12'h342, "irq_mcause", 32'h8000_0010);
    rd_csr(12'h341, "irq_mepc", 32'h400);
    rd_csr(12'h300, "irq_mstatus", 32'h0000_1880);
    rd_csr(12'h340, "irq_suppressed", 32'hDEAD_BEE0);
    rd_csr(12'h344, "mip_read", 32'h0005_0000);

    // interrupt beats exception; without MIE the exception is taken
    op(3'd0, 12'h302, 5'd0, 5'd0, 32'd0, 32'h404);
    tick();
    exc_op(5'd5, 32'hABC, 32'h500);
    chk("irq_vs_exc_newpc", newpc, 32'h1040);
    tick();
    rd_csr(12'h342, "irq_vs_exc_mcause", 32'h8000_0010);
    exc_op(5'd4, 32'h1234, 32'h600);
    chk("exc_newpc", newpc, 32'h1000);
    tick();
    rd_csr(12'h342, "exc_mcause", 32'd4);
    rd_csr(12'h343, "exc_mtval", 32'h1234);
    irq = 4'b0000;

    // halted trap commits exactly once
    op(3'd6, 12'h300, 5'd8, 5'd0, 32'd0, 32'h604);
    tick();
    hlt = 1;
    op(3'd0, 12'h000, 5'd0, 5'd0, 32'd0, 32'h700);
    chk("hlt_trap0", 32'(trap), 32'd1);
    tick();
    look();
    chk("hlt_trap1", 32'(trap), 32'd1);
    tick();
    hlt = 0;
    look();
    tick();
    rd_csr(12'h300, "hlt_mstatus", 32'h0000_1880);
    rd_csr(12'h341, "hlt_mepc", 32'h700);

    // counters
    op(3'd1, 12'hB80, 5'd0, 5'd0, 32'd0, 32'h800);
    tick();
    op(3'd1, 12'hB82, 5'd0, 5'd0, 32'd0, 32'h804);
    tick();
    op(3'd1, 12'hB02, 5'd0, 5'd0, 32'd0, 32'h808);
    tick();
    op(3'd1, 12'hB00, 5'd0, 5'd0, 32'd0, 32'h80C);
    tick();
    valid = 0; system = 0; retire = 1;
    for (int i = 0; i < 10; i++) begin
      hlt = (i == 1 || i == 3 || i == 6 || i == 8);
      tick();
    end
    hlt = 0; retire = 0;
    rd_csr(12'hB00, "mcycle10", 32'd10);
    rd_csr(12'hB02, "minstret6", 32'd6);
    op(3'd1, 12'hB00, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h810);
    tick();
    idle();
    rd_csr(12'hB80, "mcycleh_carry", 32'd1);
    rd_csr(12'hC00, "cycle_wrap", 32'd1);

    // reset during a trapping instruction
    rst = 1;
    op(3'd0, 12'h000, 5'd0, 5'd0, 32'd0, 32'h900);
    tick();
    rst = 0;
    rd_csr(12'h305, "rst_mtvec", 32'h0005_0004);
    rd_csr(12'h342, "rst_mcause", 32'd0);
    rd_csr(12'h341, "rst_mepc", 32'd0);
    rd_csr(12'h304, "rst_mie", 32'd0);
    rd_csr(12'h300, "rst_mstatus", 32'h0000_1800);

    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
